// File: rtl/params_pkg.sv
// Shared sizing and type definitions for the processor's data-memory path.
package params_pkg;
  localparam int MEM_SIZE     = 16;
  localparam int ADDR_WIDTH   = 8;
  localparam int DATA_WIDTH   = 32;
  localparam int DMEM_LATENCY = 2;

  typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} mem_size_e;
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} dmem_state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
module dmem_lane_align import params_pkg::*; #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  localparam int OFF = $clog2(DATA_WIDTH/8),
  localparam int NB  = DATA_WIDTH/8
) (
  input  logic [1:0]            size,
  input  logic [OFF-1:0]        off,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] loaded
);
  int                    nbytes, nbits;
  logic [DATA_WIDTH-1:0] shifted, lowmask;
  logic                  sext;

  always_comb begin
    nbytes = 1 << size;
    merged = word;
    for (int b = 0; b < NB; b++)
      if (b >= int'(off) && b < int'(off) + nbytes)
        merged[b*8 +: 8] = wdata[(b - int'(off))*8 +: 8];
  end

  // Sub-word loads: keep the low nbits and fill the rest with the sign (or zero).
  always_comb begin
    shifted = word >> {off, 3'b000};
    nbits   = 8 << size;
    lowmask = '0;
    sext    = 1'b0;
    loaded  = shifted;
    if (nbits < DATA_WIDTH) begin
      lowmask = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
      sext    = !is_unsigned && shifted[nbits-1];
      loaded  = (shifted & lowmask) | (sext ? ~lowmask : '0);
    end
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with request/response handshake, fixed read latency, error checks
// and a power-up sweep that writes mem[i] = i.
module dmem_ctrl import params_pkg::*; #(
  parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int LATENCY    = DMEM_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  init_done_o
);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int IW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int LW  = $clog2(LATENCY + 1);

  dmem_state_e           state;
  logic [IW-1:0]         init_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic [ADDR_WIDTH-1:0] idx;
  logic [OFF-1:0]        off, amask;
  logic                  range_err, align_err, size_err, req_err, accept;
  logic [DATA_WIDTH-1:0] rd_word, st_word, ld_word;

  assign off       = req_addr_i[OFF-1:0];
  assign idx       = req_addr_i >> OFF;
  assign amask     = OFF'((1 << req_size_i) - 1);
  assign range_err = 64'(idx) >= 64'(MEM_SIZE);
  assign align_err = |(off & amask);
  assign size_err  = (req_size_i == DWORD) && (DATA_WIDTH < 64);
  assign req_err   = range_err || align_err || size_err;
  assign rd_word   = range_err ? '0 : mem[idx[IW-1:0]];
  assign accept    = req_valid_i && req_ready_o && (state == IDLE);

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size(req_size_i), .off(off), .is_unsigned(req_unsigned_i),
    .wdata(req_wdata_i), .word(rd_word), .merged(st_word), .loaded(ld_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= INIT;
      init_cnt    <= '0;
      lat_cnt     <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      init_done_o <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          mem[init_cnt] <= DATA_WIDTH'(init_cnt);
          if (32'(init_cnt) == MEM_SIZE - 1) begin
            state       <= IDLE;
            init_done_o <= 1'b1;
            req_ready_o <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        IDLE: if (accept) begin
          // Store commits and load data is captured at the accept edge.
          if (req_we_i && !req_err) mem[idx[IW-1:0]] <= st_word;
          rsp_rdata_o <= (req_we_i || req_err) ? '0 : ld_word;
          rsp_err_o   <= req_err;
          req_ready_o <= 1'b0;
          lat_cnt     <= LW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LW'(1)) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end
        end
        RESP: if (rsp_ready_i) begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: reset/init timing, vector table through a scoreboard,
// latency with back-pressure, and reset during a pending access.
module tb_dmem_ctrl;
  import params_pkg::*;
  localparam int LAT = 3, DW = 32, AW = 8, MS = 16;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;
  logic          rsp_valid, rsp_ready, rsp_err, init_done;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_SIZE(MS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .init_done_o(init_done)
  );

  typedef struct {
    string         name;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;
  typedef struct { logic [DW-1:0] rdata; logic err; } exp_t;

  vec_t vecs[24];
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int   n;
    exp_t e;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk({v.name, " accept timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    e = sb.pop_front();
    if (!rsp_valid) begin
      chk({v.name, " response timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    chk({v.name, " rdata"}, rsp_rdata, e.rdata);
    chk({v.name, " err"}, 32'(rsp_err), 32'(e.err));
    @(posedge clk);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    //           name         we   size   uns  addr   wdata         rdata         err
    vecs[0]  = '{"lw08",      1'b0, WORD,  1'b0, 8'h08, 32'h0,        32'h00000002, 1'b0};
    vecs[1]  = '{"sb09",      1'b1, BYTE,  1'b0, 8'h09, 32'h000000AB, 32'h0,        1'b0};
    vecs[2]  = '{"lw08b",     1'b0, WORD,  1'b0, 8'h08, 32'h0,        32'h0000AB02, 1'b0};
    vecs[3]  = '{"lb09",      1'b0, BYTE,  1'b0, 8'h09, 32'h0,        32'hFFFFFFAB, 1'b0};
    vecs[4]  = '{"lbu09",     1'b0, BYTE,  1'b1, 8'h09, 32'h0,        32'h000000AB, 1'b0};
    vecs[5]  = '{"sh0e",      1'b1, HALF,  1'b0, 8'h0E, 32'h00008001, 32'h0,        1'b0};
    vecs[6]  = '{"lw0c",      1'b0, WORD,  1'b0, 8'h0C, 32'h0,        32'h80010003, 1'b0};
    vecs[7]  = '{"lh0e",      1'b0, HALF,  1'b0, 8'h0E, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[8]  = '{"lhu0e",     1'b0, HALF,  1'b1, 8'h0E, 32'h0,        32'h00008001, 1'b0};
    vecs[9]  = '{"lwu0c",     1'b0, WORD,  1'b1, 8'h0C, 32'h0,        32'h80010003, 1'b0};
    vecs[10] = '{"lw06_mis",  1'b0, WORD,  1'b0, 8'h06, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{"sh05_mis",  1'b1, HALF,  1'b0, 8'h05, 32'h0000FFFF, 32'h0,        1'b1};
    vecs[12] = '{"lw04",      1'b0, WORD,  1'b0, 8'h04, 32'h0,        32'h00000001, 1'b0};
    vecs[13] = '{"lw40_oor",  1'b0, WORD,  1'b0, 8'h40, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{"ld00_dw",   1'b0, DWORD, 1'b0, 8'h00, 32'h0,        32'h0,        1'b1};
    vecs[15] = '{"sw3c",      1'b1, WORD,  1'b0, 8'h3C, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[16] = '{"lw3c",      1'b0, WORD,  1'b0, 8'h3C, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[17] = '{"lb3f",      1'b0, BYTE,  1'b0, 8'h3F, 32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[18] = '{"sb03",      1'b1, BYTE,  1'b0, 8'h03, 32'h12345655, 32'h0,        1'b0};
    vecs[19] = '{"lw00",      1'b0, WORD,  1'b0, 8'h00, 32'h0,        32'h55000000, 1'b0};
    vecs[20] = '{"lh02",      1'b0, HALF,  1'b0, 8'h02, 32'h0,        32'h00005500, 1'b0};
    vecs[21] = '{"sw42_err",  1'b1, WORD,  1'b0, 8'h42, 32'h11111111, 32'h0,        1'b1};
    vecs[22] = '{"lb3c",      1'b0, BYTE,  1'b0, 8'h3C, 32'h0,        32'hFFFFFFEF, 1'b0};
    vecs[23] = '{"lw3e_mis",  1'b0, WORD,  1'b0, 8'h3E, 32'h0,        32'h0,        1'b1};

    // Reset values, then init_done must rise on exactly the MS-th cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= MS; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == MS - 1) chk("init_done early", 32'(init_done), 32'd0);
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("ready after init", 32'(req_ready), 32'd1);

    foreach (vecs[i]) send(vecs[i]);

    // Latency and back-pressure: load word 2 with rsp_ready held low.
    @(negedge clk);
    req_we = 1'b0; req_size = WORD; req_unsigned = 1'b0; req_addr = 8'h08;
    req_valid = 1'b1; rsp_ready = 1'b0;
    chk("lat ready before accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("lat valid cycle %0d", k + 1), 32'(rsp_valid), 32'(k == LAT - 1));
      chk($sformatf("lat ready cycle %0d", k + 1), 32'(req_ready), 32'd0);
      if (k < LAT - 1) @(posedge clk);
    end
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold valid", 32'(rsp_valid), 32'd1);
      chk("hold rdata", rsp_rdata, 32'h0000AB02);
      chk("hold err", 32'(rsp_err), 32'd0);
      chk("hold ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-hs valid", 32'(rsp_valid), 32'd0);
    chk("post-hs ready", 32'(req_ready), 32'd1);

    // Reset while a store to word 1 is waiting: no response, sweep restores 1.
    req_we = 1'b1; req_size = WORD; req_addr = 8'h04; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst valid", 32'(rsp_valid), 32'd0);
    chk("midrst init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!init_done && n < 60) begin
      @(negedge clk);
      seen |= rsp_valid;
      n++;
    end
    chk("midrst reinit", 32'(init_done), 32'd1);
    chk("midrst no rsp", 32'(seen), 32'd0);
    send('{"lw04_reinit", 1'b0, WORD, 1'b0, 8'h04, 32'h0, 32'h00000001, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data memory for the multi-cycle processor.
- Adds valid/ready request and response handshakes.
- Supports byte/half/word/dword accesses with byte-lane merge on stores and sign/zero extension on loads.
- Adds configurable read latency, error reporting, and a multi-cycle initialisation sweep.
- Sits between the core's memory-stage control FSM and word-organised storage; the core issues one request and waits for the response.

Parameters:
- MEM_SIZE, params_pkg::MEM_SIZE: number of DATA_WIDTH-bit words.
- ADDR_WIDTH, params_pkg::ADDR_WIDTH: byte-address width.
- DATA_WIDTH, params_pkg::DATA_WIDTH: word width; legal values are 32 and 64.
- LATENCY, 2: cycles from request accept to rsp_valid_o; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request can be accepted.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  mem_size_e: BYTE, HALF, WORD (32 bit), DWORD (64 bit).
- req_unsigned_i  in  1  load zero-extends when 1.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes response.
- rsp_rdata_o  out  DATA_WIDTH  load result, right-aligned and extended; 0 for stores and errors.
- rsp_err_o  out  1  misaligned, out-of-range, or illegal-size access.
- init_done_o  out  1  initialisation sweep finished.

Behaviour:
- Reset values: FSM enters INIT; init counter = 0; req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, init_done_o = 0.
- INIT: writes mem[i] = i for one word per cycle, i = 0..MEM_SIZE-1. After the last word, go to IDLE and set init_done_o = 1 (it stays 1 until reset). Requests are ignored in this state.
- IDLE: req_ready_o = 1. A request is accepted when req_valid_i && req_ready_o. On accept, go to WAIT and load the latency counter with LATENCY-1.
- WAIT: req_ready_o = 0. The counter decrements each cycle. At 0, go to RESP; for LATENCY = 1, go straight to RESP.
- RESP: rsp_valid_o = 1, with rdata and err held stable. When rsp_ready_i is high, go to IDLE; req_ready_o becomes 1 on the next cycle (no same-cycle re-accept).
- Latency: rsp_valid_o is first high exactly LATENCY cycles after the accept cycle.
- Address split: lane offset = addr[OFF-1:0], where OFF = log2(DATA_WIDTH/8). Word index = addr >> OFF.
- Errors:
  - Index >= MEM_SIZE.
  - Offset not a multiple of the access size.
  - DWORD requested when DATA_WIDTH = 32.
  - On error: no memory write, rdata = 0, err = 1. The response still follows the normal latency.
- Store: the write commits at the accept edge. Only the lanes selected by size and offset change; the low bytes of req_wdata_i are steered into those lanes.
- Load: the word is sampled at the accept edge and registered. Lanes are extracted by offset and size, then sign-extended unless req_unsigned_i is set. A load of the full DATA_WIDTH word ignores req_unsigned_i.
- Reset mid-operation: rst_i in any state drops the pending response (rsp_valid_o = 0 on the next cycle) and restarts INIT from index 0. Memory contents are overwritten by the sweep.
- Back-pressure: rsp_valid_o may be held indefinitely; nothing else changes while it is held.

Decomposition:
- params_pkg gains:
  - typedef enum logic [1:0] mem_size_e {BYTE, HALF, WORD, DWORD};
  - typedef enum dmem_state_e {INIT, IDLE, WAIT, RESP};
  - localparam DMEM_LATENCY = 2.
- Sub-module dmem_lane_align is purely combinational and contains the store merge (byte-enable generation plus data steering) and the load extract/extend.
- dmem_ctrl holds the FSM, counters, storage array and error checks.

Test Plan:
- Init sweep, DATA_WIDTH = 32, MEM_SIZE = 16 → init_done_o rises after 16 cycles; load WORD at 0x08 returns 0x00000002 with err = 0.
- Store BYTE 0xAB at 0x09, then load WORD at 0x08 → 0x0000AB02. LB at 0x09 → 0xFFFFFFAB; LBU at 0x09 → 0x000000AB.
- Store HALF 0x8001 at 0x0E → load WORD at 0x0C returns 0x80010003. LH at 0x0E → 0xFFFF8001.
- Load WORD at 0x06 and store HALF at 0x05 → both respond with err = 1 and rdata = 0; word 1 still reads 0x00000001. Address 0x40 (index 16) → err = 1. DWORD with DATA_WIDTH = 32 → err = 1.
- LATENCY = 3 with rsp_ready_i held low for 5 cycles → rsp_valid_o exactly 3 cycles after accept, data held stable throughout; req_ready_o = 0 until the cycle after the handshake.
- Assert rst_i during WAIT after a store to 0x04 → no response is produced; after re-init, the word at 0x04 reads 0x00000001.
